// File: rtl/dvp_capture_pkg.sv
// Shared types for the DVP capture path: FSM states, RGB565 layout and a window helper.
package dvp_capture_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DROP     = 2'd3
  } cap_state_t;

  // Byte 0 on the bus carries R and the top of G; byte 1 carries the rest of G and B.
  typedef struct packed {
    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
  } rgb565_t;

  function automatic logic span_hit(input int v, input int lo, input int n);
    return (v >= lo) && (v < lo + n);
  endfunction

endpackage

// File: rtl/dvp_edge_sync.sv
// Registers the raw DVP pins once and derives vsync/href edge pulses from the registered copies.
module dvp_edge_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] pic_data,
  output logic       href_r,
  output logic [7:0] data_r,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_fall
);

  logic vsync_r;
  logic vsync_q;
  logic href_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_r <= 1'b0;
      href_r  <= 1'b0;
      data_r  <= 8'd0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_r <= vsync;
      href_r  <= href;
      data_r  <= pic_data;
      vsync_q <= vsync_r;
      href_q  <= href_r;
    end
  end

  assign vsync_rise = vsync_r & ~vsync_q;
  assign vsync_fall = ~vsync_r & vsync_q;
  assign href_fall  = ~href_r & href_q;

endmodule

// File: rtl/dvp_frame_capture.sv
// DVP capture: packs byte pairs into RGB565, crops a fixed window and streams it
// into the picture FIFO, flagging frame completion, drops and malformed lines.
module dvp_frame_capture
  import dvp_capture_pkg::*;
#(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int CROP_X0 = 48,
  parameter int CROP_Y0 = 8,
  parameter int OUT_W   = 224,
  parameter int OUT_H   = 224
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  pic_data,
  input  logic        enable,
  input  logic        fifo_full,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic        pix_first,
  output logic        pix_last,
  output logic        frame_done,
  output logic        frame_drop,
  output logic        err_line,
  output logic [15:0] frame_cnt
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H);
  localparam logic [CW-1:0] X_FIRST = CW'(CROP_X0);
  localparam logic [CW-1:0] X_LAST  = CW'(CROP_X0 + OUT_W - 1);
  localparam logic [RW-1:0] Y_FIRST = RW'(CROP_Y0);
  localparam logic [RW-1:0] Y_LAST  = RW'(CROP_Y0 + OUT_H - 1);

  logic          href_r;
  logic [7:0]    data_r;
  logic          vsync_rise;
  logic          vsync_fall;
  logic          href_fall;

  cap_state_t    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          phase;
  logic [7:0]    hi_byte;

  logic          in_win;
  logic          pixel_due;
  logic          is_first;
  logic          is_last;

  dvp_edge_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .href       (href),
    .pic_data   (pic_data),
    .href_r     (href_r),
    .data_r     (data_r),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_fall  (href_fall)
  );

  // The window lies inside the sensor area, so a hit also implies col/row are unsaturated.
  assign in_win    = span_hit(int'(col), CROP_X0, OUT_W) && span_hit(int'(row), CROP_Y0, OUT_H);
  assign pixel_due = href_r && phase && in_win;
  assign is_first  = (col == X_FIRST) && (row == Y_FIRST);
  assign is_last   = (col == X_LAST) && (row == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      phase      <= 1'b0;
      hi_byte    <= 8'd0;
      pix_valid  <= 1'b0;
      pix_data   <= 16'd0;
      pix_first  <= 1'b0;
      pix_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      err_line   <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      pix_valid  <= 1'b0;
      pix_first  <= 1'b0;
      pix_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      err_line   <= 1'b0;

      if (pix_valid && pix_last) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 16'd1;
      end

      if (vsync_fall) begin
        col   <= '0;
        row   <= '0;
        phase <= 1'b0;
      end else if (href_fall) begin
        col   <= '0;
        phase <= 1'b0;
        if (row != ROW_MAX) row <= row + RW'(1);
        if ((col != COL_MAX || phase) && (state == CAPTURE || state == DROP)) err_line <= 1'b1;
      end else if (href_r) begin
        if (!phase) begin
          hi_byte <= data_r;
          phase   <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (col != COL_MAX) col <= col + CW'(1);
        end
      end

      // Leaving CAPTURE only at frame end or drop is what defers a mid-frame enable drop.
      case (state)
        IDLE:     if (enable) state <= WAIT_SOF;
        WAIT_SOF: begin
          if (!enable)        state <= IDLE;
          else if (vsync_fall) state <= CAPTURE;
        end
        CAPTURE: begin
          if (vsync_rise) begin
            frame_drop <= 1'b1;
            state      <= WAIT_SOF;
          end else if (pixel_due) begin
            if (fifo_full) begin
              frame_drop <= 1'b1;
              state      <= DROP;
            end else begin
              pix_valid <= 1'b1;
              pix_data  <= {hi_byte, data_r};
              pix_first <= is_first;
              pix_last  <= is_last;
              if (is_last) state <= WAIT_SOF;
            end
          end
        end
        DROP:     if (vsync_rise) state <= WAIT_SOF;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dvp_frame_capture.sv
// Scoreboard bench for dvp_frame_capture on a small 8x4 sensor with a 4x2 crop window.
module tb_dvp_frame_capture;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int X0 = 2;
  localparam int Y0 = 1;
  localparam int OW = 4;
  localparam int OH = 2;

  typedef struct {
    logic [15:0] data;
    bit          first;
    bit          last;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        href;
  logic [7:0]  pic_data;
  logic        enable;
  logic        fifo_full;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_first;
  logic        pix_last;
  logic        frame_done;
  logic        frame_drop;
  logic        err_line;
  logic [15:0] frame_cnt;

  int   checks = 0;
  int   passes = 0;
  int   pcnt = 0;
  int   drop_seen = 0;
  int   err_seen = 0;
  int   done_seen = 0;
  int   exp_drop = 0;
  int   exp_err = 0;
  int   exp_done = 0;
  int   exp_cnt = 0;
  bit   prev_last = 1'b0;
  exp_t sbq[$];
  exp_t got;

  dvp_frame_capture #(
    .IMG_W   (W),
    .IMG_H   (H),
    .CROP_X0 (X0),
    .CROP_Y0 (Y0),
    .OUT_W   (OW),
    .OUT_H   (OH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .href       (href),
    .pic_data   (pic_data),
    .enable     (enable),
    .fifo_full  (fifo_full),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_first  (pix_first),
    .pix_last   (pix_last),
    .frame_done (frame_done),
    .frame_drop (frame_drop),
    .err_line   (err_line),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Monitor: pops the scoreboard on every strobe and tracks the pulse outputs.
  always @(negedge clk) begin
    if (pix_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_pixel: got data %0h with empty scoreboard", pix_data);
      end else begin
        got = sbq.pop_front();
        checkOutput("pixel{cycle,data,first,last}",
                    {30'd0, pcnt[15:0], pix_data, pix_first, pix_last},
                    {30'd0, got.due[15:0], got.data, got.first, got.last});
      end
    end
    if (frame_done || prev_last) checkOutput("frame_done_after_last", 64'(frame_done), 64'(prev_last));
    prev_last = pix_valid & pix_last;
    if (frame_drop) drop_seen++;
    if (err_line)   err_seen++;
    if (frame_done) done_seen++;
  end

  task automatic drive(input logic h, input logic [7:0] d);
    @(negedge clk);
    href     = h;
    pic_data = d;
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput(name, {26'd0, pix_valid, pix_data, pix_first, pix_last,
                       frame_done, frame_drop, err_line, frame_cnt}, 64'd0);
  endtask

  // One frame from SOF to the next EOF-guard; the reference model lives inline here.
  task automatic applyStimulus(input bit rand_data, input int nrows, input int short_row,
                               input int short_len, input int full_at, input int en_off_row,
                               input int rst_row, input int rst_col);
    bit capturing;
    bit dropped;
    bit complete;
    int len;
    int k;
    logic [7:0] b0;
    logic [7:0] b1;
    exp_t e;
    capturing = enable;
    dropped   = 1'b0;
    complete  = 1'b0;
    repeat (2) drive(1'b0, 8'd0);
    vsync = 1'b0;
    repeat (2) drive(1'b0, 8'd0);
    for (int r = 0; r < nrows; r++) begin
      len = (r == short_row) ? short_len : W;
      if (r == en_off_row) enable = 1'b0;
      for (int c = 0; c < len; c++) begin
        if (r == rst_row && c == rst_col) begin
          @(negedge clk);
          rst = 1'b1;
          @(negedge clk);
          checkIdleOutputs("outputs_after_midframe_reset");
          rst = 1'b0;
          sbq.delete();
          capturing = 1'b0;
          exp_cnt   = 0;
        end
        if (rand_data) begin
          b0 = 8'($urandom);
          b1 = 8'($urandom);
        end else begin
          b0 = {4'(r), 4'(c)};
          b1 = b0;
        end
        drive(1'b1, b0);
        drive(1'b1, b1);
        if (capturing && !dropped && c >= X0 && c < X0 + OW && r >= Y0 && r < Y0 + OH) begin
          k = (r - Y0) * OW + (c - X0);
          if (k == full_at) begin
            fifo_full = 1'b1;
            dropped   = 1'b1;
          end else begin
            e.data  = {b0, b1};
            e.first = (k == 0);
            e.last  = (k == OW * OH - 1);
            e.due   = pcnt + 2;
            sbq.push_back(e);
            if (e.last) complete = 1'b1;
          end
        end
      end
      if (len != W && capturing && !complete) exp_err++;
      repeat (3) drive(1'b0, 8'd0);
    end
    @(negedge clk);
    vsync     = 1'b1;
    fifo_full = 1'b0;
    repeat (4) drive(1'b0, 8'd0);
    if (complete) begin
      exp_cnt++;
      exp_done++;
    end else if (capturing) begin
      exp_drop++;
    end
    checkOutput("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    checkOutput("frame_done_count", 64'(done_seen), 64'(exp_done));
    checkOutput("frame_drop_count", 64'(drop_seen), 64'(exp_drop));
    checkOutput("err_line_count", 64'(err_seen), 64'(exp_err));
  endtask

  initial begin
    rst       = 1'b1;
    vsync     = 1'b1;
    href      = 1'b0;
    pic_data  = 8'd0;
    enable    = 1'b1;
    fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("outputs_in_reset");
    rst = 1'b0;

    $display("[TB] clean patterned frame");
    applyStimulus(1'b0, H, -1, 0, -1, -1, -1, -1);
    $display("[TB] fifo_full on third window pixel");
    applyStimulus(1'b1, H, -1, 0, 2, -1, -1, -1);
    applyStimulus(1'b1, H, -1, 0, -1, -1, -1, -1);
    $display("[TB] short row 1");
    applyStimulus(1'b0, H, 1, W - 1, -1, -1, -1, -1);
    $display("[TB] early vsync after five window pixels");
    applyStimulus(1'b1, 3, 2, 3, -1, -1, -1, -1);
    applyStimulus(1'b1, H, -1, 0, -1, -1, -1, -1);
    $display("[TB] enable dropped mid-frame");
    applyStimulus(1'b1, H, -1, 0, -1, 1, -1, -1);
    applyStimulus(1'b1, H, -1, 0, -1, -1, -1, -1);
    enable = 1'b1;
    applyStimulus(1'b1, H, -1, 0, -1, -1, -1, -1);
    $display("[TB] reset mid-row");
    applyStimulus(1'b1, H, -1, 0, -1, -1, 1, 3);
    applyStimulus(1'b1, H, -1, 0, -1, -1, -1, -1);
    $display("[TB] random frames");
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 2) == 0)
        applyStimulus(1'b1, H, -1, 0, int'($urandom_range(0, OW * OH - 1)), -1, -1, -1);
      else
        applyStimulus(1'b1, H, -1, 0, -1, -1, -1, -1);
    end
    checkOutput("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
